// File: rtl/axi_stream_checker_pkg.sv
// Shared constants for the AXI4-Stream protocol checker: error vector layout
// and a helper for sizing saturating counters.
package axi_stream_checker_pkg;

    localparam int ERR_W                 = 7;
    localparam int ERR_DATA_UNSTABLE     = 0;
    localparam int ERR_VALID_DROP        = 1;
    localparam int ERR_STRB_KEEP         = 2;
    localparam int ERR_VALID_AFTER_RESET = 3;
    localparam int ERR_TIMEOUT           = 4;
    localparam int ERR_PKT_TOO_LONG      = 5;
    localparam int ERR_ID_SWITCH         = 6;

    typedef logic [ERR_W-1:0] err_vec_t;

    // Bits needed to hold values 0..max_val inclusive, never less than one.
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axi_stream_pkt_tracker.sv
// Packet-level bookkeeping for the stream checker: beat index, route lock,
// in_packet flag, packet counter and the over-length / route-switch detectors.
module axi_stream_pkt_tracker
    import axi_stream_checker_pkg::*;
#(
    parameter int id_width           = 1,
    parameter int dest_width         = 1,
    parameter int has_tlast          = 1,
    parameter int interleave_allowed = 0,
    parameter int max_packet_beats   = 256,
    parameter int count_width        = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   handshake,
    input  logic                   tlast,
    input  logic [id_width-1:0]    tid,
    input  logic [dest_width-1:0]  tdest,
    output logic                   in_packet,
    output logic [count_width-1:0] packet_count,
    output logic                   too_long,
    output logic                   id_switch
);

    localparam int IDX_W = ctr_width(max_packet_beats + 1);
    // Beat index seen when the first over-length beat is accepted, and the
    // saturation point that keeps the flag to one pulse per packet.
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(max_packet_beats);
    localparam logic [IDX_W-1:0] IDX_SAT   = IDX_W'(max_packet_beats + 1);

    logic                             pkt_hs;
    logic [IDX_W-1:0]                 beat_idx;
    logic [id_width+dest_width-1:0]   route;
    logic [id_width+dest_width-1:0]   locked_route;

    assign pkt_hs = handshake && (has_tlast != 0);
    assign route  = {tid, tdest};

    always_comb begin
        too_long  = 1'b0;
        id_switch = 1'b0;
        if (pkt_hs) begin
            too_long  = (max_packet_beats != 0) && (beat_idx == IDX_LIMIT);
            id_switch = (interleave_allowed == 0) && in_packet && (route != locked_route);
        end
    end

    // A lone tlast beat never opens a packet, so it neither locks a route
    // nor raises in_packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_idx     <= '0;
            locked_route <= '0;
            in_packet    <= 1'b0;
            packet_count <= '0;
        end else if (pkt_hs) begin
            if (tlast) begin
                beat_idx     <= '0;
                in_packet    <= 1'b0;
                packet_count <= packet_count + 1'b1;
            end else begin
                if (beat_idx != IDX_SAT) begin
                    beat_idx <= beat_idx + 1'b1;
                end
                if (!in_packet) begin
                    locked_route <= route;
                end
                in_packet <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI4-Stream protocol checker: samples one stream interface and
// reports handshake, stability, qualifier, timeout and packet violations.
module axi_stream_protocol_checker
    import axi_stream_checker_pkg::*;
#(
    parameter int byte_width         = 4,
    parameter int id_width           = 1,
    parameter int dest_width         = 1,
    parameter int user_width         = 1,
    parameter int has_tlast          = 1,
    parameter int interleave_allowed = 0,
    parameter int max_wait           = 16,
    parameter int max_packet_beats   = 256,
    parameter int count_width        = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    tvalid,
    input  logic                    tready,
    input  logic                    tlast,
    input  logic [8*byte_width-1:0] tdata,
    input  logic [byte_width-1:0]   tstrb,
    input  logic [byte_width-1:0]   tkeep,
    input  logic [id_width-1:0]     tid,
    input  logic [dest_width-1:0]   tdest,
    input  logic [user_width-1:0]   tuser,
    input  logic                    clear,
    output logic [ERR_W-1:0]        err_pulse,
    output logic [ERR_W-1:0]        err_sticky,
    output logic                    err_any,
    output logic                    in_packet,
    output logic [count_width-1:0]  beat_count,
    output logic [count_width-1:0]  packet_count
);

    localparam int PAYLOAD_W = 10 * byte_width + 1 + id_width + dest_width + user_width;
    localparam int WAIT_W    = ctr_width(max_wait);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(max_wait);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((max_wait > 0) ? max_wait - 1 : 0);

    logic                 stall;
    logic                 handshake;
    logic [PAYLOAD_W-1:0] payload;
    logic [PAYLOAD_W-1:0] shadow;
    logic                 stall_q;
    logic                 first_edge;
    logic [WAIT_W-1:0]    stall_cnt;
    logic                 too_long;
    logic                 id_switch;
    err_vec_t             err_now;

    assign stall     = tvalid & ~tready;
    assign handshake = tvalid & tready;
    // With packets untracked, tlast is masked so it cannot trip the stability check.
    assign payload   = {tdata, tstrb, tkeep, tlast & (has_tlast != 0), tid, tdest, tuser};

    axi_stream_pkt_tracker #(
        .id_width           (id_width),
        .dest_width         (dest_width),
        .has_tlast          (has_tlast),
        .interleave_allowed (interleave_allowed),
        .max_packet_beats   (max_packet_beats),
        .count_width        (count_width)
    ) u_pkt_tracker (
        .clk          (clk),
        .resetn       (resetn),
        .handshake    (handshake),
        .tlast        (tlast),
        .tid          (tid),
        .tdest        (tdest),
        .in_packet    (in_packet),
        .packet_count (packet_count),
        .too_long     (too_long),
        .id_switch    (id_switch)
    );

    // Timeout fires on the transition into saturation, so one long stall
    // produces a single pulse however long it lasts.
    always_comb begin
        err_now                        = '0;
        err_now[ERR_DATA_UNSTABLE]     = stall_q && (payload != shadow);
        err_now[ERR_VALID_DROP]        = stall_q && !tvalid;
        err_now[ERR_STRB_KEEP]         = tvalid && ((tstrb & ~tkeep) != '0);
        err_now[ERR_VALID_AFTER_RESET] = first_edge && tvalid;
        err_now[ERR_TIMEOUT]           = (max_wait != 0) && stall && (stall_cnt == WAIT_LAST);
        err_now[ERR_PKT_TOO_LONG]      = too_long;
        err_now[ERR_ID_SWITCH]         = id_switch;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow     <= '0;
            stall_q    <= 1'b0;
            first_edge <= 1'b1;
            stall_cnt  <= '0;
            beat_count <= '0;
        end else begin
            first_edge <= 1'b0;
            stall_q    <= stall;
            if (stall) begin
                shadow <= payload;
                if (stall_cnt != WAIT_MAX) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
            if (handshake) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end

    // An error detected in the same cycle as clear survives the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_pulse  <= '0;
            err_sticky <= '0;
        end else begin
            err_pulse  <= err_now;
            err_sticky <= (clear ? '0 : err_sticky) | err_now;
        end
    end

    assign err_any = |err_sticky;

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Testbench for axi_stream_protocol_checker: directed vector table, multi-cycle
// corner cases and a randomized run against an event-level reference model.
module tb_axi_stream_protocol_checker;
    import axi_stream_checker_pkg::*;

    localparam int BYTE_W   = 4;
    localparam int ID_W     = 2;
    localparam int MAX_WAIT = 16;
    localparam int MAX_PKT  = 256;
    localparam int CW       = 32;
    localparam int PW       = 10 * BYTE_W + 1 + ID_W + 1 + 1;

    typedef struct packed {
        logic        v;
        logic        r;
        logic        l;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  id;
        logic        dest;
        logic        user;
        logic        clr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [6:0] exp_pulse;
        logic [6:0] exp_sticky;
        logic       exp_in_pkt;
        int         exp_beats;
        int         exp_pkts;
    } vec_t;

    logic              clk;
    logic              resetn;
    logic              tvalid, tready, tlast, clear;
    logic [31:0]       tdata;
    logic [3:0]        tstrb, tkeep;
    logic [ID_W-1:0]   tid;
    logic [0:0]        tdest, tuser;
    logic [ERR_W-1:0]  err_pulse, err_sticky, il_err_pulse, il_err_sticky;
    logic              err_any, in_packet, il_err_any, il_in_packet;
    logic [CW-1:0]     beat_count, packet_count, il_beat_count, il_packet_count;

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state, kept as plain event counts.
    logic          m_prev_stall, m_first, m_pkt_open;
    logic [PW-1:0] m_shadow;
    int            m_stall_run, m_beats, m_beat_count, m_pkt_count;
    logic [2:0]    m_lock;
    logic [6:0]    m_pulse, m_sticky, m_sticky_il;

    axi_stream_protocol_checker #(
        .byte_width(BYTE_W), .id_width(ID_W), .dest_width(1), .user_width(1),
        .has_tlast(1), .interleave_allowed(0), .max_wait(MAX_WAIT),
        .max_packet_beats(MAX_PKT), .count_width(CW)
    ) dut (
        .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tid(tid), .tdest(tdest),
        .tuser(tuser), .clear(clear), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_any(err_any), .in_packet(in_packet), .beat_count(beat_count),
        .packet_count(packet_count)
    );

    axi_stream_protocol_checker #(
        .byte_width(BYTE_W), .id_width(ID_W), .dest_width(1), .user_width(1),
        .has_tlast(1), .interleave_allowed(1), .max_wait(MAX_WAIT),
        .max_packet_beats(MAX_PKT), .count_width(CW)
    ) dut_il (
        .clk(clk), .resetn(resetn), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tid(tid), .tdest(tdest),
        .tuser(tuser), .clear(clear), .err_pulse(il_err_pulse), .err_sticky(il_err_sticky),
        .err_any(il_err_any), .in_packet(il_in_packet), .beat_count(il_beat_count),
        .packet_count(il_packet_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic r, input logic l,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [3:0] keep, input logic [1:0] id,
                                 input logic clr);
        stim_t s;
        s.v = v; s.r = r; s.l = l; s.data = data; s.strb = strb; s.keep = keep;
        s.id = id; s.dest = 1'b0; s.user = 1'b0; s.clr = clr;
        return s;
    endfunction

    function automatic logic [PW-1:0] cur_payload();
        return {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_prev_stall = 1'b0; m_first = 1'b1; m_pkt_open = 1'b0; m_shadow = '0;
        m_stall_run = 0; m_beats = 0; m_beat_count = 0; m_pkt_count = 0; m_lock = '0;
        m_pulse = '0; m_sticky = '0; m_sticky_il = '0;
    endtask

    // Applies the protocol rules to the inputs sampled at one rising edge.
    task automatic modelStep();
        logic [6:0] e;
        logic hs, st;
        e  = '0;
        hs = tvalid && tready;
        st = tvalid && !tready;
        if (m_prev_stall && cur_payload() != m_shadow) e[ERR_DATA_UNSTABLE] = 1'b1;
        if (m_prev_stall && !tvalid) e[ERR_VALID_DROP] = 1'b1;
        if (tvalid && (tstrb & ~tkeep) != 4'h0) e[ERR_STRB_KEEP] = 1'b1;
        if (m_first && tvalid) e[ERR_VALID_AFTER_RESET] = 1'b1;
        m_stall_run = st ? m_stall_run + 1 : 0;
        if (m_stall_run == MAX_WAIT) e[ERR_TIMEOUT] = 1'b1;
        if (hs) begin
            m_beats++;
            m_beat_count++;
            if (m_beats == MAX_PKT + 1) e[ERR_PKT_TOO_LONG] = 1'b1;
            if (m_pkt_open && {tid, tdest} != m_lock) e[ERR_ID_SWITCH] = 1'b1;
            if (!m_pkt_open && !tlast) m_lock = {tid, tdest};
            if (tlast) begin
                m_pkt_count++;
                m_pkt_open = 1'b0;
                m_beats = 0;
            end else begin
                m_pkt_open = 1'b1;
            end
        end
        if (st) m_shadow = cur_payload();
        m_prev_stall = st;
        m_first      = 1'b0;
        m_pulse      = e;
        m_sticky     = (clear ? 7'h00 : m_sticky) | e;
        m_sticky_il  = (clear ? 7'h00 : m_sticky_il) | (e & 7'h3F);
    endtask

    task automatic checkOutput();
        check("err_pulse", 64'(err_pulse), 64'(m_pulse));
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        check("err_any", 64'(err_any), 64'(|m_sticky));
        check("in_packet", 64'(in_packet), 64'(m_pkt_open));
        check("beat_count", 64'(beat_count), 64'(32'(m_beat_count)));
        check("packet_count", 64'(packet_count), 64'(32'(m_pkt_count)));
        check("il_err_sticky", 64'(il_err_sticky), 64'(m_sticky_il));
    endtask

    task automatic applyStimulus(input stim_t s);
        tvalid = s.v; tready = s.r; tlast = s.l; tdata = s.data; tstrb = s.strb;
        tkeep = s.keep; tid = s.id; tdest = s.dest; tuser = s.user; clear = s.clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Asserts reset away from any clock edge, so outputs must clear asynchronously.
    task automatic doReset();
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        vec_t  tbl[15];
        stim_t s, prev;
        int    hits, hit_at;
        logic  hold;

        resetn = 1'b1;
        applyIdle();
        #1;
        doReset();

        tbl[0]  = '{mk(0,0,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b0, 0, 0};
        tbl[1]  = '{mk(1,0,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b0, 0, 0};
        tbl[2]  = '{mk(1,0,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b0, 0, 0};
        tbl[3]  = '{mk(1,0,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b0, 0, 0};
        tbl[4]  = '{mk(1,1,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b1, 1, 0};
        tbl[5]  = '{mk(1,0,0,32'hA5,4'hF,4'hF,0,0), 7'h00, 7'h00, 1'b1, 1, 0};
        tbl[6]  = '{mk(1,0,0,32'h5A,4'hF,4'hF,0,0), 7'h01, 7'h01, 1'b1, 1, 0};
        tbl[7]  = '{mk(1,0,0,32'h5A,4'hF,4'hF,0,0), 7'h00, 7'h01, 1'b1, 1, 0};
        tbl[8]  = '{mk(1,1,0,32'h5A,4'hF,4'hF,0,0), 7'h00, 7'h01, 1'b1, 2, 0};
        tbl[9]  = '{mk(1,1,1,32'h00,4'hF,4'hF,0,0), 7'h00, 7'h01, 1'b0, 3, 1};
        tbl[10] = '{mk(0,0,0,32'h00,4'hF,4'hF,0,1), 7'h00, 7'h00, 1'b0, 3, 1};
        tbl[11] = '{mk(1,1,1,32'h00,4'h3,4'h1,0,0), 7'h04, 7'h04, 1'b0, 4, 2};
        tbl[12] = '{mk(1,0,0,32'h00,4'hF,4'hF,0,0), 7'h00, 7'h04, 1'b0, 4, 2};
        tbl[13] = '{mk(0,0,0,32'h00,4'hF,4'hF,0,1), 7'h02, 7'h02, 1'b0, 4, 2};
        tbl[14] = '{mk(0,0,0,32'h00,4'hF,4'hF,0,0), 7'h00, 7'h02, 1'b0, 4, 2};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].s);
            check($sformatf("tbl%0d_pulse", i), 64'(err_pulse), 64'(tbl[i].exp_pulse));
            check($sformatf("tbl%0d_sticky", i), 64'(err_sticky), 64'(tbl[i].exp_sticky));
            check($sformatf("tbl%0d_in_pkt", i), 64'(in_packet), 64'(tbl[i].exp_in_pkt));
            check($sformatf("tbl%0d_beats", i), 64'(beat_count), 64'(32'(tbl[i].exp_beats)));
            check($sformatf("tbl%0d_pkts", i), 64'(packet_count), 64'(32'(tbl[i].exp_pkts)));
        end

        // One long stall: a single timeout pulse on the 16th stalled edge.
        hits = 0; hit_at = 0;
        for (int i = 1; i <= 36; i++) begin
            applyStimulus(mk(1,0,0,32'h1234,4'hF,4'hF,0,0));
            if (err_pulse[ERR_TIMEOUT]) begin
                hits++;
                hit_at = i;
            end
        end
        check("timeout_pulses", 64'(hits), 64'd1);
        check("timeout_edge", 64'(hit_at), 64'(MAX_WAIT));
        applyStimulus(mk(1,1,1,32'h1234,4'hF,4'hF,0,0));

        // Route switch mid-packet: flagged only where interleaving is disallowed.
        applyStimulus(mk(0,0,0,32'h0,4'hF,4'hF,0,1));
        applyStimulus(mk(1,1,0,32'h11,4'hF,4'hF,2,0));
        applyStimulus(mk(1,1,1,32'h22,4'hF,4'hF,3,0));
        check("id_switch_strict", 64'(err_sticky[ERR_ID_SWITCH]), 64'd1);
        check("id_switch_interleave", 64'(il_err_sticky[ERR_ID_SWITCH]), 64'd0);

        // 257-beat packet: over-length flagged on the last beat only.
        doReset();
        hits = 0; hit_at = 0;
        for (int b = 1; b <= MAX_PKT + 1; b++) begin
            applyStimulus(mk(1,1,(b == MAX_PKT + 1),32'(b),4'hF,4'hF,1,0));
            if (err_pulse[ERR_PKT_TOO_LONG]) begin
                hits++;
                hit_at = b;
            end
        end
        check("pkt_long_pulses", 64'(hits), 64'd1);
        check("pkt_long_beat", 64'(hit_at), 64'(MAX_PKT + 1));
        check("pkt_long_count", 64'(packet_count), 64'd1);
        check("pkt_long_in_pkt", 64'(in_packet), 64'd0);

        // Randomized traffic, mostly holding payload through stalls.
        prev = mk(0,0,0,32'h0,4'hF,4'hF,0,0);
        for (int i = 0; i < 800; i++) begin
            hold = prev.v && !prev.r && ($urandom_range(9) != 0);
            if (hold) begin
                s = prev;
            end else begin
                s.v    = ($urandom_range(3) != 0);
                s.l    = ($urandom_range(7) == 0);
                s.data = $urandom;
                s.strb = 4'($urandom_range(15));
                s.keep = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'hF;
                s.id   = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'd1;
                s.dest = ($urandom_range(7) == 0);
                s.user = 1'($urandom_range(1));
            end
            s.r   = (((i / 100) % 2) == 1) ? ($urandom_range(19) == 0) : 1'($urandom_range(1));
            s.clr = ($urandom_range(15) == 0);
            applyStimulus(s);
            prev = s;
        end

        // Reset mid-packet and mid-stall, then valid on the first edge after release.
        applyStimulus(mk(1,1,0,32'hAB,4'h3,4'h1,1,0));
        applyStimulus(mk(1,0,0,32'hCD,4'hF,4'hF,1,0));
        doReset();
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_in_pkt", 64'(in_packet), 64'd0);
        check("rst_beats", 64'(beat_count), 64'd0);
        applyStimulus(mk(1,1,1,32'hEE,4'h3,4'h1,0,0));
        check("after_rst_valid", 64'(err_sticky[ERR_VALID_AFTER_RESET]), 64'd1);
        check("after_rst_strb", 64'(err_sticky[ERR_STRB_KEEP]), 64'd1);
        applyStimulus(mk(1,1,1,32'hEF,4'hF,4'hF,0,0));
        check("second_edge_pulse", 64'(err_pulse), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    task automatic applyIdle();
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tdata = '0; tstrb = '0;
        tkeep = '0; tid = '0; tdest = '0; tuser = '0; clear = 1'b0;
    endtask

endmodule
